// File: rtl/imem_pkg.sv
// Shared types and default geometry for the instruction memory and its arbiter.
// The instruction RAM uses the same geometry constants.
package imem_pkg;

  localparam int IMEM_ADDR_WIDTH = 32;
  localparam int IMEM_DATA_WIDTH = 32;
  localparam int IMEM_MEM_SIZE   = 512;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } port_e;

  // Describes the single outstanding response: who asked, whether it was out of range, and whether it was a write.
  typedef struct packed {
    port_e port;
    logic  oor;
    logic  we;
  } resp_tag_t;

endpackage

// File: rtl/imem_range_chk.sv
// Converts a byte address to a word index and flags whether that index lies inside the memory.
module imem_range_chk #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [$clog2(MEM_SIZE)-1:0] idx,
  output logic                        in_range
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_SIZE);

  logic [ADDR_WIDTH-3:0] word;
  logic                  unused_low;

  assign word       = addr[ADDR_WIDTH-1:2];
  assign idx        = word[IDX_W-1:0];
  assign in_range   = (word < WORD_LIMIT);
  // Byte offset within a word is irrelevant for word-wide instruction accesses.
  assign unused_low = &{1'b0, addr[1:0]};

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter (fetch F, loader L) for one synchronous-read instruction RAM.
// Optional macro IMEM_ARB_LOCK_EN adds l_lock, which gives L exclusive access.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH   = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = IMEM_DATA_WIDTH,
  parameter int MEM_SIZE     = IMEM_MEM_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        f_req,
  input  logic [ADDR_WIDTH-1:0]       f_addr,
  output logic                        f_gnt,
  output logic                        f_rvalid,
  output logic [DATA_WIDTH-1:0]       f_rdata,
  input  logic                        l_req,
  input  logic                        l_we,
  input  logic [ADDR_WIDTH-1:0]       l_addr,
  input  logic [DATA_WIDTH-1:0]       l_wdata,
`ifdef IMEM_ARB_LOCK_EN
  input  logic                        l_lock,
`endif
  output logic                        l_gnt,
  output logic                        l_rvalid,
  output logic [DATA_WIDTH-1:0]       l_rdata,
  output logic                        l_err,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] port_addr     [2];
  logic [IDX_W-1:0]      port_idx      [2];
  logic                  port_in_range [2];

  logic             lock;
  logic             starved;
  logic [CNT_W-1:0] starve_reg, starve_next;
  logic             resp_valid_reg;
  resp_tag_t        tag_reg, tag_next;

  assign port_addr[PORT_F] = f_addr;
  assign port_addr[PORT_L] = l_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_range
    imem_range_chk #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_SIZE   (MEM_SIZE)
    ) u_range_chk (
      .addr     (port_addr[gi]),
      .idx      (port_idx[gi]),
      .in_range (port_in_range[gi])
    );
  end

`ifdef IMEM_ARB_LOCK_EN
  assign lock = l_lock;
`else
  assign lock = 1'b0;
`endif

  assign starved = (starve_reg == LIMIT);

  // F wins by default; L takes the slot when F is idle, when L has starved, or when locked.
  always_comb begin
    l_gnt = !rst && l_req && (lock || starved || !f_req);
    f_gnt = !rst && f_req && !lock && !(l_req && starved);
  end

  always_comb begin
    starve_next = starve_reg;
    if (lock || !l_req || l_gnt) begin
      starve_next = '0;
    end else if (!starved) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  always_comb begin
    mem_en    = (f_gnt && port_in_range[PORT_F]) || (l_gnt && port_in_range[PORT_L]);
    mem_we    = l_gnt && l_we && port_in_range[PORT_L];
    mem_addr  = l_gnt ? port_idx[PORT_L] : port_idx[PORT_F];
    mem_wdata = l_wdata;
  end

  always_comb begin
    tag_next      = '0;
    tag_next.port = l_gnt ? PORT_L : PORT_F;
    tag_next.oor  = l_gnt ? !port_in_range[PORT_L] : !port_in_range[PORT_F];
    tag_next.we   = l_gnt && l_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg     <= '0;
      resp_valid_reg <= 1'b0;
      tag_reg        <= '0;
    end else begin
      starve_reg     <= starve_next;
      resp_valid_reg <= f_gnt || l_gnt;
      tag_reg        <= tag_next;
    end
  end

  // Responses are suppressed during reset so a grant just before reset never surfaces.
  always_comb begin
    f_rvalid = !rst && resp_valid_reg && (tag_reg.port == PORT_F);
    l_rvalid = !rst && resp_valid_reg && (tag_reg.port == PORT_L);
    f_rdata  = (f_rvalid && !tag_reg.oor) ? mem_rdata : '0;
    l_rdata  = (l_rvalid && !tag_reg.oor && !tag_reg.we) ? mem_rdata : '0;
    l_err    = l_rvalid && tag_reg.oor;
  end

endmodule
